display_mode_ctrl: RTL and testbench

- Generates the 5-bit display-state code consumed by the 5-to-1 display value selector.
- Turns one-cycle button pulses into mode and field selection, drives a timed alarm-view overlay, and applies an idle timeout in alarm-set mode.
- Sits between the debounce/one-pulse stage and the display value mux.
- Its output is the selector's `state` input.

---
 rtl/display_mode_ctrl_if.sv | 34 +++
 rtl/display_mode_ctrl.sv | 155 +++++++++++++++
 tb/tb_display_mode_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/display_mode_ctrl_if.sv
// rtl/display_mode_ctrl_if.sv - button pulse / display-state bundle for display_mode_ctrl
//
// Purpose: groups the one-cycle button pulses coming from the one-pulse stage
// and the display-state code going to the 5-to-1 display value selector.
// Signals:
//   btn_mode   1  pulse, advance to the next mode
//   btn_next   1  pulse, advance to the next field
//   btn_alarm  1  pulse, toggle alarm overlay (clock mode only)
//   state      5  display-state code {mode[1:0], field[1:0], overlay}
//   mode_chg   1  pulse, mode bits just changed
// Modports: master drives the buttons, slave (the controller) drives state.
interface display_mode_ctrl_if;
  logic       btn_mode;
  logic       btn_next;
  logic       btn_alarm;
  logic [4:0] state;
  logic       mode_chg;

  modport master (
    output btn_mode,
    output btn_next,
    output btn_alarm,
    input  state,
    input  mode_chg
  );

  modport slave (
    input  btn_mode,
    input  btn_next,
    input  btn_alarm,
    output state,
    output mode_chg
  );
endinterface

// File: rtl/display_mode_ctrl.sv
// rtl/display_mode_ctrl.sv - display mode / field / alarm-overlay controller
//
// Purpose: turns one-cycle button pulses into the 5-bit display-state code
// consumed by the display value selector. Handles mode cycling, field
// stepping, a timed alarm-view overlay and an idle timeout in alarm-set mode.
// Ports:
//   clk    1  system clock, rising edge
//   rst_n  1  asynchronous active-low reset
//   bus    display_mode_ctrl_if.slave
//            btn_mode/btn_next/btn_alarm in, state[4:0]/mode_chg out
// Parameters:
//   SHOW_CYC  cycles the overlay bit stays high after an alarm request
//   IDLE_CYC  pulse-free cycles in alarm-set mode before returning to clock
module display_mode_ctrl #(
  parameter int unsigned SHOW_CYC = 100_000_000,
  parameter int unsigned IDLE_CYC = 500_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_mode_ctrl_if.slave   bus
);

  localparam int unsigned SHOW_W = $clog2(SHOW_CYC + 1);
  localparam int unsigned IDLE_W = $clog2(IDLE_CYC + 1);

  localparam logic [SHOW_W-1:0] SHOW_LOAD = SHOW_W'(SHOW_CYC);
  localparam logic [SHOW_W-1:0] SHOW_ONE  = SHOW_W'(1);
  // The timeout fires on the edge that completes the IDLE_CYC-th pulse-free
  // cycle, i.e. when IDLE_CYC-1 pulse-free cycles have already been counted.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  // Mode encodings are the literal state[4:3] codes the selector expects.
  typedef enum logic [1:0] {
    MODE_CLOCK = 2'b00,
    MODE_STW   = 2'b10,
    MODE_ASET  = 2'b01
  } mode_e;

  mode_e             mode_q,     mode_d;
  logic [1:0]        field_q,    field_d;
  logic              ovl_q,      ovl_d;
  logic [SHOW_W-1:0] show_cnt_q, show_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              mode_chg_q, mode_chg_d;

  logic              any_btn;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_CLOCK: next_mode = MODE_STW;
      MODE_STW:   next_mode = MODE_ASET;
      default:    next_mode = MODE_CLOCK;
    endcase
  endfunction

  // Clock mode has three fields: 00 -> 01 -> 10 -> 00.
  function automatic logic [1:0] next_clock_field(input logic [1:0] f);
    case (f)
      2'b00:   next_clock_field = 2'b01;
      2'b01:   next_clock_field = 2'b10;
      default: next_clock_field = 2'b00;
    endcase
  endfunction

  // Gray walk 00 -> 01 -> 11 -> 10 -> 00 written as a bit rotation with
  // inversion, so only one field bit toggles per step.
  function automatic logic [1:0] next_gray_field(input logic [1:0] f);
    next_gray_field = {f[0], ~f[1]};
  endfunction

  assign any_btn = bus.btn_mode | bus.btn_next | bus.btn_alarm;

  always_comb begin
    mode_d     = mode_q;
    field_d    = field_q;
    ovl_d      = ovl_q;
    show_cnt_d = show_cnt_q;
    idle_cnt_d = idle_cnt_q;
    mode_chg_d = 1'b0;

    // Background overlay countdown; the counter holds the number of cycles
    // the overlay is still visible including the current one.
    if (ovl_q) begin
      if (show_cnt_q <= SHOW_ONE) begin
        ovl_d      = 1'b0;
        show_cnt_d = '0;
      end else begin
        show_cnt_d = show_cnt_q - SHOW_ONE;
      end
    end

    // Idle counter only runs in alarm-set mode; any pulse restarts it.
    if (mode_q == MODE_ASET && !any_btn) begin
      idle_cnt_d = idle_cnt_q + IDLE_ONE;
    end else begin
      idle_cnt_d = '0;
    end

    // Only the highest-priority pulse acts; lower ones are dropped.
    if (bus.btn_mode) begin
      mode_d     = next_mode(mode_q);
      field_d    = 2'b00;
      ovl_d      = 1'b0;
      show_cnt_d = '0;
      idle_cnt_d = '0;
      mode_chg_d = 1'b1;
    end else if (bus.btn_next) begin
      if (mode_q == MODE_CLOCK) begin
        field_d = next_clock_field(field_q);
      end else begin
        field_d = next_gray_field(field_q);
      end
    end else if (bus.btn_alarm) begin
      if (mode_q == MODE_CLOCK) begin
        if (ovl_q) begin
          ovl_d      = 1'b0;
          show_cnt_d = '0;
        end else begin
          ovl_d      = 1'b1;
          show_cnt_d = SHOW_LOAD;
        end
      end
    end else if (mode_q == MODE_ASET && idle_cnt_q == IDLE_LAST) begin
      mode_d     = MODE_CLOCK;
      field_d    = 2'b00;
      ovl_d      = 1'b0;
      show_cnt_d = '0;
      idle_cnt_d = '0;
      mode_chg_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_CLOCK;
      field_q    <= 2'b00;
      ovl_q      <= 1'b0;
      show_cnt_q <= '0;
      idle_cnt_q <= '0;
      mode_chg_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      field_q    <= field_d;
      ovl_q      <= ovl_d;
      show_cnt_q <= show_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      mode_chg_q <= mode_chg_d;
    end
  end

  assign bus.state    = {mode_q, field_q, ovl_q};
  assign bus.mode_chg = mode_chg_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// tb/tb_display_mode_ctrl.sv - self-checking bench for display_mode_ctrl
module tb_display_mode_ctrl;

  localparam int SHOW = 4;
  localparam int IDLE = 8;

  logic clk;
  logic rst_n;

  display_mode_ctrl_if bus ();

  display_mode_ctrl #(
    .SHOW_CYC (SHOW),
    .IDLE_CYC (IDLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: modes as an index 0=CLOCK 1=STW 2=ASET, fields as a
  // position in that mode's walk, overlay as remaining visible cycles.
  int m_mode, m_fpos, m_ovl_left, m_idle;
  bit m_chg;

  function automatic logic [4:0] model_code(int md, int fp, int ovl_left);
    logic [1:0] mbits [3];
    logic [1:0] clk_f [3];
    logic [1:0] gray_f [4];
    logic [1:0] f;
    mbits  = '{2'b00, 2'b10, 2'b01};
    clk_f  = '{2'b00, 2'b01, 2'b10};
    gray_f = '{2'b00, 2'b01, 2'b11, 2'b10};
    f = (md == 0) ? clk_f[fp] : gray_f[fp];
    return {mbits[md], f, (ovl_left > 0)};
  endfunction

  initial begin
    m_mode = 0; m_fpos = 0; m_ovl_left = 0; m_idle = 0; m_chg = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_fpos = 0; m_ovl_left = 0; m_idle = 0; m_chg = 0;
      end else begin
        int ovl_before;
        ovl_before = m_ovl_left;
        m_chg = 0;
        if (m_ovl_left > 0) m_ovl_left--;
        if (bus.btn_mode) begin
          m_mode = (m_mode + 1) % 3;
          m_fpos = 0; m_ovl_left = 0; m_idle = 0; m_chg = 1;
        end else if (bus.btn_next) begin
          m_fpos = (m_fpos + 1) % ((m_mode == 0) ? 3 : 4);
          m_idle = 0;
        end else if (bus.btn_alarm) begin
          m_idle = 0;
          if (m_mode == 0) m_ovl_left = (ovl_before > 0) ? 0 : SHOW;
        end else if (m_mode == 2) begin
          m_idle++;
          if (m_idle == IDLE) begin
            m_mode = 0; m_fpos = 0; m_idle = 0; m_chg = 1;
          end
        end else begin
          m_idle = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("model_state", bus.state, model_code(m_mode, m_fpos, m_ovl_left));
        check("model_mode_chg", {4'b0, bus.mode_chg}, {4'b0, m_chg});
      end
    end
  end

  // Drive a pulse for one edge, then check the literal result.
  task automatic pulse(input string name, input bit bm, input bit bn, input bit ba,
                       input logic [4:0] exp, input bit exp_chg);
    bus.btn_mode  = bm;
    bus.btn_next  = bn;
    bus.btn_alarm = ba;
    @(negedge clk);
    bus.btn_mode  = 1'b0;
    bus.btn_next  = 1'b0;
    bus.btn_alarm = 1'b0;
    check(name, bus.state, exp);
    check({name, "_chg"}, {4'b0, bus.mode_chg}, {4'b0, exp_chg});
  endtask

  task automatic idle_chk(input string name, input int n, input logic [4:0] exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, bus.state, exp);
    end
  endtask

  initial begin
    bus.btn_mode  = 1'b0;
    bus.btn_next  = 1'b0;
    bus.btn_alarm = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", bus.state, 5'b00000);
    check("reset_chg", {4'b0, bus.mode_chg}, 5'b0);
    rst_n = 1'b1;
    idle_chk("post_reset", 2, 5'b00000);

    // Mode cycling
    pulse("mode1", 1, 0, 0, 5'b10000, 1);
    pulse("mode2", 1, 0, 0, 5'b01000, 1);
    pulse("mode3", 1, 0, 0, 5'b00000, 1);
    @(negedge clk);
    check("chg_drop", {4'b0, bus.mode_chg}, 5'b0);

    // Field walks
    pulse("clk_f1", 0, 1, 0, 5'b00010, 0);
    pulse("clk_f2", 0, 1, 0, 5'b00100, 0);
    pulse("clk_f3", 0, 1, 0, 5'b00000, 0);
    pulse("to_stw", 1, 0, 0, 5'b10000, 1);
    pulse("stw_f1", 0, 1, 0, 5'b10010, 0);
    pulse("stw_f2", 0, 1, 0, 5'b10110, 0);
    pulse("stw_f3", 0, 1, 0, 5'b10100, 0);
    pulse("stw_f4", 0, 1, 0, 5'b10000, 0);
    pulse("to_aset", 1, 0, 0, 5'b01000, 1);
    pulse("aset_f1", 0, 1, 0, 5'b01010, 0);
    pulse("aset_f2", 0, 1, 0, 5'b01110, 0);
    pulse("aset_f3", 0, 1, 0, 5'b01100, 0);
    pulse("aset_f4", 0, 1, 0, 5'b01000, 0);
    pulse("to_clock", 1, 0, 0, 5'b00000, 1);

    // Overlay: exactly SHOW cycles
    pulse("ovl_field", 0, 1, 0, 5'b00010, 0);
    pulse("ovl_on", 0, 0, 1, 5'b00011, 0);
    idle_chk("ovl_hold", SHOW - 1, 5'b00011);
    idle_chk("ovl_end", 2, 5'b00010);
    // Cancel at cycle 2
    pulse("ovl_on2", 0, 0, 1, 5'b00011, 0);
    pulse("ovl_cancel", 0, 0, 1, 5'b00010, 0);
    idle_chk("ovl_cancelled", SHOW, 5'b00010);
    // Field step during overlay, overlay keeps its schedule
    pulse("ovl_on3", 0, 0, 1, 5'b00011, 0);
    pulse("ovl_next", 0, 1, 0, 5'b00101, 0);
    idle_chk("ovl_next_hold", SHOW - 2, 5'b00101);
    idle_chk("ovl_next_end", 1, 5'b00100);
    pulse("clk_wrap", 0, 1, 0, 5'b00000, 0);

    // Idle timeout
    pulse("it_m1", 1, 0, 0, 5'b10000, 1);
    pulse("it_m2", 1, 0, 0, 5'b01000, 1);
    pulse("it_n1", 0, 1, 0, 5'b01010, 0);
    pulse("it_n2", 0, 1, 0, 5'b01110, 0);
    idle_chk("idle_hold", IDLE - 1, 5'b01110);
    @(negedge clk);
    check("idle_fire", bus.state, 5'b00000);
    check("idle_fire_chg", {4'b0, bus.mode_chg}, 5'b1);
    // Timer restart on a pulse at idle cycle 7
    pulse("ir_m1", 1, 0, 0, 5'b10000, 1);
    pulse("ir_m2", 1, 0, 0, 5'b01000, 1);
    pulse("ir_n1", 0, 1, 0, 5'b01010, 0);
    pulse("ir_n2", 0, 1, 0, 5'b01110, 0);
    idle_chk("ir_hold", IDLE - 2, 5'b01110);
    pulse("ir_next", 0, 1, 0, 5'b01100, 0);
    idle_chk("ir_hold2", IDLE - 1, 5'b01100);
    @(negedge clk);
    check("ir_fire", bus.state, 5'b00000);
    check("ir_fire_chg", {4'b0, bus.mode_chg}, 5'b1);

    // Simultaneous pulses and ignored alarm
    pulse("simul", 1, 1, 1, 5'b10000, 1);
    pulse("stw_alarm", 0, 0, 1, 5'b10000, 0);
    pulse("to_aset2", 1, 0, 0, 5'b01000, 1);
    pulse("aset_alarm", 0, 0, 1, 5'b01000, 0);
    pulse("aset_next", 0, 1, 0, 5'b01010, 0);
    pulse("back_clock", 1, 0, 0, 5'b00000, 1);

    // Asynchronous reset mid-sequence from 10110
    pulse("rs_m", 1, 0, 0, 5'b10000, 1);
    pulse("rs_n1", 0, 1, 0, 5'b10010, 0);
    pulse("rs_n2", 0, 1, 0, 5'b10110, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", bus.state, 5'b00000);
    check("async_rst_chg", {4'b0, bus.mode_chg}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_chk("after_rst", 3, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
